univ_shift_reg_seq: RTL and testbench
=====================================

// Module: univ_shift_reg_seq
// PURPOSE
//  Parametrised N-bit universal shift register with a shift-count sequencer.
//  A single start pulse runs a multi-cycle operation: logical shift, rotate, or arithmetic shift, K steps.
//  Single-cycle operations are parallel load and clear.
//  Intended as the datapath register for serialisers, bit-serial ALUs and barrel-shift emulation.
// PARAMETERS
//  N      8  register width (N >= 2)
//  CNT_W  4  width of shift-count input / internal remaining-step counter
// PORTS
//  clk     in   1      rising-edge clock
//  clr     in   1      reset, synchronous, active-high
//  start   in   1      op request; sampled only while busy=0
//  mode    in   3      op select, sampled with start
//  cnt     in   CNT_W  number of steps for multi-cycle ops, sampled with start
//  din_r   in   1      serial in for shift-up (enters q[0]), sampled every shift step
//  din_l   in   1      serial in for shift-down (enters q[N-1]), sampled every shift step
//  p_load  in   N      parallel load data, sampled with start
//  q       out  N      register contents
//  dout_r  out  1      q[N-1] (combinational from q)
//  dout_l  out  1      q[0] (combinational from q)
//  busy    out  1      registered; high while a multi-cycle op is in progress
//  done    out  1      registered; one-cycle pulse when an op completes
// BEHAVIOUR
//  Reset (clr=1 at an edge)
//   - q=0, busy=0, done=0, state=IDLE, remaining=0.
//   - clr has priority over everything, including an op in progress; the op is aborted and no done pulse is issued.
//  Modes (one step)
//   - 000 hold
//   - 001 shift up: q<={q[N-2:0],din_r}
//   - 010 shift down: q<={din_l,q[N-1:1]}
//   - 011 load: q<=p_load
//   - 100 rotate up: q<={q[N-2:0],q[N-1]}
//   - 101 rotate down: q<={q[0],q[N-1:1]}
//   - 110 arithmetic shift down: q<={q[N-1],q[N-1:1]}
//   - 111 clear: q<=0
//  FSM states
//   - IDLE: busy=0.
//   - RUN: busy=1. Holds latched mode and remaining count.
//  Single-cycle ops
//   - Condition: IDLE, start=1, and either mode in {000,011,111} or cnt=0.
//   - At that edge E0: apply the op (cnt=0 leaves q unchanged) and set done<=1.
//   - State stays IDLE; busy never rises.
//  Multi-cycle ops (IDLE, start=1, mode in {001,010,100,101,110}, cnt=K>=1)
//   - Edge E0: latch mode, remaining<=K, state->RUN, busy<=1. q is unchanged at E0.
//   - Edges E1..EK: one step each, remaining decrements by 1. Serial inputs are sampled live at each step.
//   - Edge EK: state->IDLE, busy<=0, done<=1.
//   - Net effect: exactly K steps; done is high in the cycle after EK; total latency K+1 edges.
//  Ordering and timing rules
//   - start while busy=1 is ignored; mode/cnt/p_load changes during RUN have no effect.
//   - done is 0 in every cycle except the single completion cycle.
//   - A new start may be issued in the same cycle done=1 and is accepted (back-to-back ops).
//   - K may exceed N: steps continue regardless. Rotate by N restores the original q; logical shift by >=N flushes in serial data.
//   - remaining is unsigned CNT_W bits; no wrap, since it only decrements from K to 0.
// TESTING
//  1. Reset / load: clr=1 with q=8'hFF -> q=0, busy=0, done=0. Then start, mode=011, p_load=8'hA5 -> q=8'hA5, done pulses 1 cycle, busy stays 0.
//  2. Shift up: q=8'h81, mode=001, cnt=3, din_r=1 throughout -> q after E1..E3 = 8'h03, 8'h07, 8'h0F; busy high 3 cycles then done pulse.
//  3. Rotate/arith: q=8'h96, mode=100, cnt=8 -> q=8'h96, done after 9 edges. Then q=8'h90, mode=110, cnt=2 -> q=8'hE4.
//  4. Ignore and back-to-back: start asserted again with mode=111 during RUN -> ignored, q is not cleared. Start on the done cycle -> accepted immediately.
//  5. Reset mid-op: mode=010, cnt=5, clr at E2 -> q=0, busy=0, no done pulse. Next start proceeds normally.
//  6. cnt=0: mode=001, cnt=0 -> q unchanged, done pulses at E0+1, busy never high.

Source files
------------

// File: rtl/univ_shift_reg_seq.sv
// Universal N-bit shift register with a step-count sequencer: one start pulse
// runs K shift/rotate/arithmetic steps, or a single-cycle load/clear/hold.
module univ_shift_reg_seq #(
    parameter int N     = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] cnt,
    input  logic             din_r,
    input  logic             din_l,
    input  logic [N-1:0]     p_load,
    output logic [N-1:0]     q,
    output logic             dout_r,
    output logic             dout_l,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_SHL  = 3'b001;
    localparam logic [2:0] M_SHR  = 3'b010;
    localparam logic [2:0] M_LOAD = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ROR  = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;
    localparam logic [2:0] M_CLR  = 3'b111;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [2:0]       mode_reg, mode_next;
    logic [CNT_W-1:0] remaining_reg, remaining_next;
    logic [N-1:0]     q_reg, q_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;

    logic             is_multi_mode;
    logic             accept;
    logic             accept_single;
    logic             accept_multi;
    logic             last_step;
    logic             step_up;
    logic             step_down;
    logic [N-1:0]     step_q;

    // Requests only count while idle; during RUN every input but the serial
    // data is ignored, which is what makes start-while-busy harmless.
    assign is_multi_mode = (mode == M_SHL) || (mode == M_SHR) || (mode == M_ROL) ||
                           (mode == M_ROR) || (mode == M_ASR);
    assign accept        = (state_reg == IDLE) && start;
    assign accept_multi  = accept && is_multi_mode && (cnt != CNT_ZERO);
    assign accept_single = accept && !accept_multi;
    assign last_step     = (state_reg == RUN) && (remaining_reg == CNT_ONE);

    // One-step datapath, driven by the latched mode only.
    assign step_up   = (mode_reg == M_SHL) || (mode_reg == M_ROL);
    assign step_down = (mode_reg == M_SHR) || (mode_reg == M_ROR) || (mode_reg == M_ASR);

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_step
            logic from_below;
            logic from_above;

            if (gi == 0) begin : g_lsb
                assign from_below = (mode_reg == M_ROL) ? q_reg[N-1] : din_r;
            end else begin : g_mid_lo
                assign from_below = q_reg[gi-1];
            end

            if (gi == N - 1) begin : g_msb
                assign from_above = (mode_reg == M_ROR) ? q_reg[0] :
                                    (mode_reg == M_ASR) ? q_reg[N-1] : din_l;
            end else begin : g_mid_hi
                assign from_above = q_reg[gi+1];
            end

            assign step_q[gi] = step_up   ? from_below :
                                step_down ? from_above : q_reg[gi];
        end
    endgenerate

    // State register (also holds the datapath registers)
    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg     <= IDLE;
            mode_reg      <= M_HOLD;
            remaining_reg <= '0;
            q_reg         <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            mode_reg      <= mode_next;
            remaining_reg <= remaining_next;
            q_reg         <= q_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept_multi) state_next = RUN;
            RUN:  if (last_step)    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs
    always_comb begin
        busy_next = (state_next == RUN);
        done_next = accept_single || last_step;
    end

    // Datapath next values
    always_comb begin
        q_next         = q_reg;
        mode_next      = mode_reg;
        remaining_next = remaining_reg;
        if (state_reg == RUN) begin
            q_next         = step_q;
            remaining_next = remaining_reg - CNT_ONE;
        end else if (accept_multi) begin
            mode_next      = mode;
            remaining_next = cnt;
        end else if (accept_single) begin
            // Shift-type modes with cnt=0 fall through and leave q alone.
            case (mode)
                M_LOAD:  q_next = p_load;
                M_CLR:   q_next = '0;
                default: q_next = q_reg;
            endcase
        end
    end

    assign q      = q_reg;
    assign dout_r = q_reg[N-1];
    assign dout_l = q_reg[0];
    assign busy   = busy_reg;
    assign done   = done_reg;

endmodule

// File: tb/tb_univ_shift_reg_seq.sv
// Scoreboard bench for univ_shift_reg_seq: each op pushes its per-edge
// expected {q,busy,done} trace, which is popped and compared after each edge.
module tb_univ_shift_reg_seq;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       start = 1'b0;
    logic [2:0] mode = 3'b000;
    logic [3:0] cnt = 4'd0;
    logic       din_r = 1'b0;
    logic       din_l = 1'b0;
    logic [7:0] p_load = 8'h00;
    logic [7:0] q;
    logic       dout_r, dout_l, busy, done;

    typedef struct packed {
        logic [7:0] q;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mq;
    int         tests_run = 0;
    int         tests_failed = 0;

    univ_shift_reg_seq #(.N(8), .CNT_W(4)) dut (
        .clk(clk), .clr(clr), .start(start), .mode(mode), .cnt(cnt),
        .din_r(din_r), .din_l(din_l), .p_load(p_load),
        .q(q), .dout_r(dout_r), .dout_l(dout_l), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_step(input logic [7:0] v, input logic [2:0] m,
                                              input logic dr, input logic dl);
        logic [7:0] r;
        case (m)
            3'b001:  r = (v << 1) | {7'b0, dr};
            3'b010:  r = (v >> 1) | {dl, 7'b0};
            3'b100:  r = (v << 1) | (v >> 7);
            3'b101:  r = (v >> 1) | (v << 7);
            3'b110:  r = 8'($signed(v) >>> 1);
            default: r = v;
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one op right away (back-to-back if called on a done cycle),
    // then checks every edge until its expected trace is exhausted.
    task automatic run_op(input string name, input logic [2:0] m, input logic [3:0] k,
                          input logic [7:0] pl, input logic [15:0] drp, input logic [15:0] dlp,
                          input bit poke, input int abort_at);
        bit   multi;
        exp_t ex;
        multi = (m == 3'b001 || m == 3'b010 || m == 3'b100 || m == 3'b101 || m == 3'b110)
                && (k != 4'd0);
        if (!multi) begin
            if (m == 3'b011) mq = pl;
            else if (m == 3'b111) mq = 8'h00;
            sb.push_back({mq, 1'b0, 1'b1});
        end else begin
            sb.push_back({mq, 1'b1, 1'b0});
            for (int s = 1; s <= int'(k); s++) begin
                mq = model_step(mq, m, drp[s-1], dlp[s-1]);
                sb.push_back({mq, (s != int'(k)), (s == int'(k))});
            end
        end
        if (abort_at > 0) begin
            while (sb.size() > abort_at) void'(sb.pop_back());
            sb.push_back({8'h00, 1'b0, 1'b0});
            sb.push_back({8'h00, 1'b0, 1'b0});
            mq = 8'h00;
        end

        start = 1'b1; mode = m; cnt = k; p_load = pl;
        for (int e = 0; sb.size() > 0; e++) begin
            tick();
            ex = sb.pop_front();
            $display("[TB] %s edge %0d: q=%02h busy=%0b done=%0b", name, e, q, busy, done);
            check_val({name, ".q"}, {24'h0, q}, {24'h0, ex.q});
            check_val({name, ".busy"}, {31'h0, busy}, {31'h0, ex.busy});
            check_val({name, ".done"}, {31'h0, done}, {31'h0, ex.done});
            if (poke && ex.busy) begin
                start  = 1'b1;
                mode   = 3'b111;
                cnt    = 4'($urandom_range(0, 15));
                p_load = 8'($urandom);
            end else begin
                start  = 1'b0;
            end
            din_r = (e < 16) ? drp[e] : 1'b0;
            din_l = (e < 16) ? dlp[e] : 1'b0;
            clr   = (abort_at > 0) && (e + 1 == abort_at);
        end
        start = 1'b0;
        clr   = 1'b0;
    endtask

    initial begin
        mq = 8'h00;
        // 1: reset, load FF, clear by clr, then load A5
        tick();
        tick();
        check_val("rst.q", {24'h0, q}, 32'h0);
        check_val("rst.busy", {31'h0, busy}, 32'h0);
        check_val("rst.done", {31'h0, done}, 32'h0);
        clr = 1'b0;
        run_op("load_ff", 3'b011, 4'd0, 8'hFF, 16'h0, 16'h0, 0, 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        mq  = 8'h00;
        check_val("clr.q", {24'h0, q}, 32'h0);
        check_val("clr.busy", {31'h0, busy}, 32'h0);
        check_val("clr.done", {31'h0, done}, 32'h0);
        run_op("load_a5", 3'b011, 4'd0, 8'hA5, 16'h0, 16'h0, 0, 0);
        check_val("load_a5.const", {24'h0, q}, 32'hA5);
        check_val("load_a5.dout_r", {31'h0, dout_r}, 32'h1);

        // 2: shift up 3 with din_r=1
        run_op("load_81", 3'b011, 4'd0, 8'h81, 16'h0, 16'h0, 0, 0);
        run_op("shl3", 3'b001, 4'd3, 8'h00, 16'hFFFF, 16'h0, 0, 0);
        check_val("shl3.const", {24'h0, q}, 32'h0F);

        // 3: rotate by N restores; arithmetic shift keeps sign
        run_op("load_96", 3'b011, 4'd0, 8'h96, 16'h0, 16'h0, 0, 0);
        run_op("rol8", 3'b100, 4'd8, 8'h00, 16'h0, 16'h0, 0, 0);
        check_val("rol8.const", {24'h0, q}, 32'h96);
        run_op("load_90", 3'b011, 4'd0, 8'h90, 16'h0, 16'h0, 0, 0);
        run_op("asr2", 3'b110, 4'd2, 8'h00, 16'h0, 16'hFFFF, 0, 0);
        check_val("asr2.const", {24'h0, q}, 32'hE4);

        // 4: start during RUN ignored, then back-to-back ops
        run_op("load_3c", 3'b011, 4'd0, 8'h3C, 16'h0, 16'h0, 0, 0);
        run_op("shr4_poke", 3'b010, 4'd4, 8'h00, 16'h0, 16'b1010, 1, 0);
        run_op("ror3_b2b", 3'b101, 4'd3, 8'h00, 16'h0, 16'h0, 1, 0);
        run_op("hold", 3'b000, 4'd5, 8'h11, 16'h0, 16'h0, 0, 0);
        run_op("shl12", 3'b001, 4'd12, 8'h00, 16'h0A5C, 16'h0, 0, 0);
        run_op("rol15", 3'b100, 4'd15, 8'h00, 16'h0, 16'h0, 0, 0);
        run_op("clr_op", 3'b111, 4'd3, 8'h00, 16'h0, 16'h0, 0, 0);

        // 5: reset mid-op, then a normal op
        run_op("load_c3", 3'b011, 4'd0, 8'hC3, 16'h0, 16'h0, 0, 0);
        run_op("shr5_abort", 3'b010, 4'd5, 8'h00, 16'h0, 16'hFFFF, 0, 2);
        run_op("load_b7", 3'b011, 4'd0, 8'hB7, 16'h0, 16'h0, 0, 0);
        run_op("shr2_after", 3'b010, 4'd2, 8'h00, 16'h0, 16'b01, 0, 0);

        // 6: cnt=0 on a shift mode is a one-cycle no-op
        run_op("shl0", 3'b001, 4'd0, 8'h00, 16'hFFFF, 16'h0, 0, 0);
        check_val("shl0.const", {24'h0, q}, {24'h0, mq});

        tick();
        check_val("idle.done", {31'h0, done}, 32'h0);
        check_val("idle.busy", {31'h0, busy}, 32'h0);
        check_val("idle.q", {24'h0, q}, {24'h0, mq});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
